instr_sequencer: RTL and testbench

Producer end of the processor's DIN/Run/Done instruction interface; replaces manual switch entry of instructions and immediates. Holds a small program RAM, loaded word-by-word from board switches while idle. On start, it issues each instruction with a 1-cycle Run pulse and supplies the immediate word for mvi. It waits for Done, then advances until the program length is reached. Sits in the board top level between the switch/key inputs and processor_multiciclo.

---
 rtl/instr_sequencer_pkg.sv | 27 ++
 rtl/instr_sequencer_prog_ram.sv | 36 +++
 rtl/instr_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg
// Shared definitions for the instruction sequencer: FSM state encoding,
// processor opcodes and instruction field positions.
package instr_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    localparam logic [2:0] MV  = 3'b000;
    localparam logic [2:0] MVI = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;

    // Instruction field positions within a 16-bit word
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int RX_MSB  = 5;
    localparam int RX_LSB  = 3;
    localparam int RY_MSB  = 2;
    localparam int RY_LSB  = 0;

endpackage

// File: rtl/instr_sequencer_prog_ram.sv
// seq_prog_ram
// DEPTH x 16 program store: synchronous write, two combinational read ports.
// Contents are not reset.
// Ports:
//   clk              rising-edge clock
//   we/waddr/wdata   write port
//   raddr_a/rdata_a  read port A
//   raddr_b/rdata_b  read port B
module seq_prog_ram
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WORD_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WORD_W-1:0] rdata_b
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Producer side of the processor DIN/Run/Done interface. A program is loaded
// into a small RAM while idle, then issued one instruction at a time: a
// one-cycle Run pulse with the instruction on DIN, followed (for mvi) by the
// immediate word on DIN until Done returns.
// Optional build macro: SEQ_TIMEOUT_EN enables a WAIT-state watchdog that
// abandons the program after TIMEOUT_CYC cycles without Done.
// Ports:
//   Clock, Resetn          clock, asynchronous active-low reset
//   start, abort           begin program (IDLE only) / return to IDLE
//   wr_en/wr_addr/wr_data  program RAM write (IDLE only)
//   prog_len               program length in RAM words (clamped to DEPTH)
//   Done                   instruction complete, from processor
//   DIN, Run               registered word and issue strobe to processor
//   busy, pc               status: not IDLE / current instruction address
//   instr_count            instructions completed since start (saturating)
//   prog_done              one-cycle pulse at end of program
//   timeout_err            sticky watchdog flag
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter logic [2:0] OPC_MVI     = MVI,
    parameter int         TIMEOUT_CYC = 64,
    localparam int        ADDR_W      = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              Done,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              prog_done,
    output logic              timeout_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    seq_state_t        state_q, state_d;
    logic [15:0]       din_q, din_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        step_q, step_d;
    logic [15:0]       count_q, count_d;
    logic              prog_done_q, prog_done_d;
    logic              timeout_q, timeout_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   npc;
    logic [ADDR_W-1:0] raddr_a, raddr_b;
    logic [15:0]       rdata_a, rdata_b;

    assign len_eff = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign npc     = {1'b0, pc_q} + {{(ADDR_W - 1){1'b0}}, step_q};

    // Port A: word 0 for a fresh start, current instruction in ISSUE,
    // next instruction while waiting. Port B: immediate following pc.
    always_comb begin
        raddr_a = '0;
        case (state_q)
            ISSUE:   raddr_a = pc_q;
            WAIT:    raddr_a = npc[ADDR_W-1:0];
            default: raddr_a = '0;
        endcase
    end
    assign raddr_b = pc_q + ADDR_W'(1);

    seq_prog_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (Clock),
        .we      (wr_en && (state_q == IDLE)),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        run_d       = 1'b0;
        pc_d        = pc_q;
        step_d      = step_q;
        count_d     = count_q;
        prog_done_d = 1'b0;
        timeout_d   = timeout_q;
`ifdef SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
`endif

        case (state_q)
            IDLE: begin
                din_d = '0;
                if (start && (prog_len != '0)) begin
                    pc_d      = '0;
                    count_d   = '0;
                    timeout_d = 1'b0;
                    run_d     = 1'b1;
                    state_d   = ISSUE;
                    // A write to word 0 on the start edge must be visible
                    // in the first issued word.
                    din_d = (wr_en && (wr_addr == '0)) ? wr_data : rdata_a;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
                if (rdata_a[OPC_MSB:OPC_LSB] == OPC_MVI) begin
                    din_d  = rdata_b;
                    step_d = 2'd2;
                end else begin
                    step_d = 2'd1;
                end
            end
            WAIT: begin
                if (Done) begin
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    if (npc >= len_eff) begin
                        prog_done_d = 1'b1;
                        pc_d        = '0;
                        din_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        pc_d    = npc[ADDR_W-1:0];
                        din_d   = rdata_a;
                        run_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    timeout_d = 1'b1;
                    pc_d      = '0;
                    din_d     = '0;
                    state_d   = IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                din_d   = '0;
                pc_d    = '0;
            end
        endcase

        // abort wins over everything but keeps the completion count
        if (abort) begin
            state_d     = IDLE;
            run_d       = 1'b0;
            din_d       = '0;
            pc_d        = '0;
            count_d     = count_q;
            timeout_d   = timeout_q;
            prog_done_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            din_q       <= '0;
            run_q       <= 1'b0;
            pc_q        <= '0;
            step_q      <= 2'd1;
            count_q     <= '0;
            prog_done_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            run_q       <= run_d;
            pc_q        <= pc_d;
            step_q      <= step_d;
            count_q     <= count_d;
            prog_done_q <= prog_done_d;
            timeout_q   <= timeout_d;
`ifdef SEQ_TIMEOUT_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign DIN         = din_q;
    assign Run         = run_q;
    assign busy        = (state_q != IDLE);
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign prog_done   = prog_done_q;
`ifdef SEQ_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: expected issue/immediate words are generated
// from a local copy of the program and queued when start is driven.
module tb_instr_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [4:0]  prog_len = '0;
    logic        Done = 1'b0;
    logic [15:0] DIN;
    logic        Run;
    logic        busy;
    logic [3:0]  pc;
    logic [15:0] instr_count;
    logic        prog_done;
    logic        timeout_err;

    instr_sequencer dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .abort(abort),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_len(prog_len), .Done(Done), .DIN(DIN), .Run(Run),
        .busy(busy), .pc(pc), .instr_count(instr_count),
        .prog_done(prog_done), .timeout_err(timeout_err)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] issue_w;
        logic [15:0] wait_w;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] model_mem [16];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic load_word(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        @(negedge Clock);
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic load_basic();
        load_word(0, 16'h0040);
        load_word(1, 16'h0005);
        load_word(2, 16'h0008);
    endtask

    task automatic build_expected(input int len);
        int p, le;
        logic [15:0] w;
        sb.delete();
        le = (len > 16) ? 16 : len;
        p = 0;
        while (p < le) begin
            w = model_mem[p];
            if (w[8:6] == 3'b001) begin
                sb.push_back('{issue_w: w, wait_w: model_mem[(p + 1) % 16]});
                p += 2;
            end else begin
                sb.push_back('{issue_w: w, wait_w: w});
                p += 1;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input int len, input int lat,
                                 input bit wr0, input logic [15:0] wr0_data);
        sb_t e;
        int cnt, waited;
        if (wr0) model_mem[0] = wr0_data;
        build_expected(len);
        prog_len = 5'(len);
        if (wr0) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = wr0_data; end
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0; wr_en = 1'b0;
        cnt = 0;
        while (sb.size() > 0) begin
            waited = 0;
            while (Run !== 1'b1 && waited < 10) begin @(negedge Clock); waited++; end
            e = sb.pop_front();
            n_checks++;
            if (Run !== 1'b1) begin
                $display("FAIL %s_run_wait: Run=%b after %0d cycles, required 1", tag, Run, waited);
                return;
            end else n_pass++;
            n_checks++;
            if (DIN !== e.issue_w) $display("FAIL %s_issue: DIN=%h required %h", tag, DIN, e.issue_w);
            else n_pass++;
            @(negedge Clock);
            n_checks++;
            if (Run !== 1'b0 || DIN !== e.wait_w)
                $display("FAIL %s_wait: Run=%b DIN=%h required Run=0 DIN=%h", tag, Run, DIN, e.wait_w);
            else n_pass++;
            repeat (lat) @(negedge Clock);
            n_checks++;
            if (DIN !== e.wait_w) $display("FAIL %s_hold: DIN=%h required %h", tag, DIN, e.wait_w);
            else n_pass++;
            Done = 1'b1;
            @(negedge Clock);
            Done = 1'b0;
            cnt++;
        end
        n_checks++;
        if (prog_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s_end: prog_done=%b busy=%b required 1/0", tag, prog_done, busy);
        else n_pass++;
        n_checks++;
        if (instr_count !== 16'(cnt)) $display("FAIL %s_count: got %0d required %0d", tag, instr_count, cnt);
        else n_pass++;
        @(negedge Clock);
        n_checks++;
        if (prog_done !== 1'b0) $display("FAIL %s_pulse: prog_done=%b required 0", tag, prog_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        n_checks++;
        if ({DIN, Run, busy, pc, instr_count, prog_done, timeout_err} !== '0)
            $display("FAIL reset: DIN=%h Run=%b busy=%b pc=%h cnt=%h pd=%b to=%b required all 0",
                     DIN, Run, busy, pc, instr_count, prog_done, timeout_err);
        else n_pass++;
        Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_basic();
        load_basic();
        run_and_check("basic", 3, 3, 1'b0, 16'h0);
    endtask

    task automatic test_start_write_same_edge();
        run_and_check("start_wr", 3, 0, 1'b1, 16'h0010);
    endtask

    task automatic test_back_to_back();
        load_word(0, 16'h0008);
        load_word(1, 16'h0011);
        load_word(2, 16'h004A);
        load_word(3, 16'h1234);
        load_word(4, 16'h0050);
        load_word(5, 16'hABCD);
        run_and_check("b2b_mvi_last", 5, 0, 1'b0, 16'h0);
        for (int i = 0; i < 15; i++) load_word(i, 16'h0008 + 16'(i));
        load_word(15, 16'h0040);
        run_and_check("clamp_wrap", 31, 0, 1'b0, 16'h0);
    endtask

    task automatic test_abort();
        load_basic();
        prog_len = 5'd3;
        start = 1'b1; @(negedge Clock); start = 1'b0;
        @(negedge Clock);
        Done = 1'b1; @(negedge Clock); Done = 1'b0;
        n_checks++;
        if (Run !== 1'b1 || DIN !== 16'h0008) $display("FAIL abort_issue2: Run=%b DIN=%h required 1/0008", Run, DIN);
        else n_pass++;
        @(negedge Clock);
        abort = 1'b1; @(negedge Clock); abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || DIN !== 16'h0 || pc !== 4'h0 || instr_count !== 16'd1 || prog_done !== 1'b0)
            $display("FAIL abort_state: busy=%b DIN=%h pc=%h cnt=%0d pd=%b required 0/0000/0/1/0",
                     busy, DIN, pc, instr_count, prog_done);
        else n_pass++;
        @(negedge Clock);
        n_checks++;
        if (prog_done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_after: pd=%b busy=%b required 0/0", prog_done, busy);
        else n_pass++;
    endtask

    task automatic test_write_busy();
        prog_len = 5'd3;
        start = 1'b1; @(negedge Clock); start = 1'b0;
        @(negedge Clock);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        @(negedge Clock);
        wr_en = 1'b0; abort = 1'b1;
        @(negedge Clock);
        abort = 1'b0;
        run_and_check("wr_busy_rerun", 3, 1, 1'b0, 16'h0);
    endtask

    task automatic test_stall();
        int busy_cnt, to_seen, pd_seen;
        prog_len = 5'd3;
        start = 1'b1; @(negedge Clock); start = 1'b0;
        busy_cnt = 0; to_seen = 0; pd_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (timeout_err === 1'b1) to_seen++;
            if (prog_done === 1'b1) pd_seen++;
            @(negedge Clock);
        end
        n_checks++;
        if (pd_seen != 0) $display("FAIL stall_prog_done: pulses=%0d required 0", pd_seen);
        else n_pass++;
`ifdef SEQ_TIMEOUT_EN
        n_checks++;
        if (busy_cnt != 65) $display("FAIL stall_busy_cycles: got %0d required 65", busy_cnt);
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || Run !== 1'b0 || DIN !== 16'h0)
            $display("FAIL stall_timeout: to=%b busy=%b Run=%b DIN=%h required 1/0/0/0000",
                     timeout_err, busy, Run, DIN);
        else n_pass++;
        run_and_check("after_timeout", 3, 0, 1'b0, 16'h0);
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_clear: to=%b required 0", timeout_err);
        else n_pass++;
`else
        n_checks++;
        if (busy_cnt != 100 || to_seen != 0)
            $display("FAIL stall_no_wdog: busy_cycles=%0d to_cycles=%0d required 100/0", busy_cnt, to_seen);
        else n_pass++;
        abort = 1'b1; @(negedge Clock); abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stall_abort: busy=%b required 0", busy);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        prog_len = 5'd3;
        start = 1'b1; @(negedge Clock); start = 1'b0;
        n_checks++;
        if (Run !== 1'b1) $display("FAIL areset_pre: Run=%b required 1", Run);
        else n_pass++;
        #2 Resetn = 1'b0;
        #1;
        n_checks++;
        if (Run !== 1'b0 || DIN !== 16'h0 || busy !== 1'b0 || pc !== 4'h0)
            $display("FAIL areset_now: Run=%b DIN=%h busy=%b pc=%h required 0", Run, DIN, busy, pc);
        else n_pass++;
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        n_checks++;
        if (busy !== 1'b0 || Run !== 1'b0) $display("FAIL areset_idle: busy=%b Run=%b required 0/0", busy, Run);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        prog_len = 5'd0;
        start = 1'b1; @(negedge Clock); start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || Run !== 1'b0) $display("FAIL zero_len: busy=%b Run=%b required 0/0", busy, Run);
        else n_pass++;
        @(negedge Clock);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL zero_len_later: busy=%b required 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_write_same_edge();
        test_back_to_back();
        test_abort();
        test_write_busy();
        test_stall();
        test_async_reset();
        test_zero_len();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
